rob_commit_queue: RTL and testbench
===================================

// Module: rob_commit_queue
// PURPOSE
//  In-order completion queue that writes the architectural register file. Issue allocates
//  one entry per instruction. The CDB marks entries done by ROB index. The head entry
//  retires in program order by driving regfile load/dest/in. Sits between issue/CDB and the
//  register file as the single writer of the register file.
// PARAMETERS
//  data_width     16  width of result data (register width)
//  tag_width       3  register-number width (8 architectural regs)
//  rob_idx_width   3  ROB index width; depth = 2**rob_idx_width (power of two by construction)
// PORTS
//  clk            in   1              rising-edge clock
//  reset          in   1              synchronous, active-high reset
//  alloc_valid    in   1              issue requests an entry this cycle
//  alloc_has_dest in   1              instruction writes a register (0 for ST/BR/etc.)
//  alloc_dest     in   tag_width      destination register number
//  alloc_ready    out  1              queue not full (count < depth)
//  alloc_idx      out  rob_idx_width  index granted on alloc (= tail pointer)
//  cdb_valid      in   1              result broadcast valid
//  cdb_idx        in   rob_idx_width  ROB index of broadcast result
//  cdb_data       in   data_width     result value
//  flush          in   1              discard all in-flight entries (mispredict)
//  regfile_load   out  1              register file write enable
//  regfile_dest   out  tag_width      register file write address
//  regfile_in     out  data_width     register file write data
//  commit_valid   out  1              head entry retires this cycle (with or without write)
//  empty          out  1              count == 0
//  count          out  rob_idx_width+1 occupied entries
// BEHAVIOUR
//  - Entry state: valid, done, has_dest, dest, data. Pointers head/tail wrap modulo depth.
//  - Reset (sync): all valid/done=0, head=tail=0, count=0. The following outputs read 0:
//    regfile_load, commit_valid, alloc_idx, count. empty=1 and alloc_ready=1.
//  - Alloc: if alloc_valid && alloc_ready, at the edge write entry[tail] = {valid=1, done=0,
//    has_dest, dest}, tail++. alloc_ready depends on count only. A commit in the same cycle
//    does NOT free a slot for that cycle's alloc. alloc_valid while full is ignored.
//  - CDB: if cdb_valid && entry[cdb_idx].valid, set done=1 and data=cdb_data at the edge.
//    A broadcast to an invalid entry is ignored. Duplicate broadcasts overwrite data.
//  - Commit: combinational from registered state only. commit_valid = head.valid & head.done
//    & !flush. regfile_load = commit_valid & head.has_dest. regfile_dest/regfile_in come
//    from head.dest/head.data. On commit, at the edge clear head.valid and increment head.
//  - Latency: CDB in cycle N, then commit visible in cycle N+1, then register file updated at
//    the end of N+1. At most one commit per cycle.
//  - Simultaneous alloc+commit: count unchanged. Alloc into the slot being retired is
//    impossible (full blocks alloc).
//  - CDB to head in the same cycle head is not yet done: no commit this cycle; commit next.
//  - Flush: highest priority over alloc, CDB and commit. It suppresses commit_valid and
//    regfile_load in the flush cycle. At the edge, state matches reset.
//  - Reset mid-operation: identical to flush. Pending results are lost.
//  - count == depth means full. Pointers alone are ambiguous, so count disambiguates
//    full from empty.
// STRUCTURE
//  - lc3b_types: add rob_entry_t struct {valid, done, has_dest, dest, data} and ROB_DEPTH.
//  - One sub-module, rob_entry_array: depth x rob_entry_t storage with alloc write port,
//    CDB write port and head read port. Control (pointers, count, flush) stays in the top.
//  - Outputs regfile_load/regfile_dest/regfile_in connect directly to the register file's
//    load/dest/in.
// TESTING
//  1 reset -> empty=1, count=0, alloc_ready=1, alloc_idx=0, regfile_load=0, commit_valid=0
//  2 alloc R3 (idx0), R5 (idx1). CDB idx1=0xBEEF, then idx0=0x1234: no commit until idx0
//    done. Then load=1 dest=3 in=0x1234, next cycle dest=5 in=0xBEEF.
//  3 alloc 8 -> alloc_ready=0, count=8. A 9th alloc_valid is ignored. CDB idx0: commit next
//    cycle, alloc_ready=1 the cycle after, count=7.
//  4 20 alloc/CDB/commit pairs: alloc_idx wraps 7->0. Regfile writes appear in alloc order
//    with correct data. count never exceeds 8.
//  5 alloc has_dest=0, then CDB: commit_valid=1, regfile_load=0, head advances, count-1
//  6 3 entries done plus flush in the same cycle: regfile_load=0 that cycle. Next cycle:
//    empty=1, alloc_idx=0. CDB to an old idx is ignored.

Source files
------------

// File: rtl/rob_commit_queue_pkg.sv
// Shared widths and the ROB entry record for the in-order commit queue.
package rob_commit_queue_pkg;

    localparam int unsigned data_width    = 16;
    localparam int unsigned tag_width     = 3;
    localparam int unsigned rob_idx_width = 3;
    localparam int unsigned ROB_DEPTH     = 2 ** rob_idx_width;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  has_dest;
        logic [tag_width-1:0]  dest;
        logic [data_width-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_queue_if.sv
// Issue/CDB/regfile signal bundle for the commit queue; slave is the queue side.
interface rob_commit_queue_if;
    import rob_commit_queue_pkg::*;

    logic                     alloc_valid;
    logic                     alloc_has_dest;
    logic [tag_width-1:0]     alloc_dest;
    logic                     alloc_ready;
    logic [rob_idx_width-1:0] alloc_idx;
    logic                     cdb_valid;
    logic [rob_idx_width-1:0] cdb_idx;
    logic [data_width-1:0]    cdb_data;
    logic                     flush;
    logic                     regfile_load;
    logic [tag_width-1:0]     regfile_dest;
    logic [data_width-1:0]    regfile_in;
    logic                     commit_valid;
    logic                     empty;
    logic [rob_idx_width:0]   count;

    modport master (
        output alloc_valid, alloc_has_dest, alloc_dest, cdb_valid, cdb_idx, cdb_data, flush,
        input  alloc_ready, alloc_idx, regfile_load, regfile_dest, regfile_in, commit_valid,
               empty, count
    );

    modport slave (
        input  alloc_valid, alloc_has_dest, alloc_dest, cdb_valid, cdb_idx, cdb_data, flush,
        output alloc_ready, alloc_idx, regfile_load, regfile_dest, regfile_in, commit_valid,
               empty, count
    );

endinterface

// File: rtl/rob_commit_queue_entry_array.sv
// ROB entry storage: alloc write port, CDB write port, retire clear and head read port.
module rob_commit_queue_entry_array
    import rob_commit_queue_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     clear_i,
    input  logic                     alloc_we_i,
    input  logic [rob_idx_width-1:0] alloc_idx_i,
    input  logic                     alloc_has_dest_i,
    input  logic [tag_width-1:0]     alloc_dest_i,
    input  logic                     cdb_we_i,
    input  logic [rob_idx_width-1:0] cdb_idx_i,
    input  logic [data_width-1:0]    cdb_data_i,
    input  logic                     retire_we_i,
    input  logic [rob_idx_width-1:0] head_idx_i,
    output rob_entry_t               head_entry_o
);

    rob_entry_t mem_q [ROB_DEPTH];

    // Only valid/done need clearing; dest/data are don't-care in an invalid slot.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            for (int i = 0; i < int'(ROB_DEPTH); i++) begin
                mem_q[i].valid <= 1'b0;
                mem_q[i].done  <= 1'b0;
            end
        end else begin
            if (alloc_we_i) begin
                mem_q[alloc_idx_i].valid    <= 1'b1;
                mem_q[alloc_idx_i].done     <= 1'b0;
                mem_q[alloc_idx_i].has_dest <= alloc_has_dest_i;
                mem_q[alloc_idx_i].dest     <= alloc_dest_i;
            end
            if (cdb_we_i && mem_q[cdb_idx_i].valid) begin
                mem_q[cdb_idx_i].done <= 1'b1;
                mem_q[cdb_idx_i].data <= cdb_data_i;
            end
            if (retire_we_i) begin
                mem_q[head_idx_i].valid <= 1'b0;
                mem_q[head_idx_i].done  <= 1'b0;
            end
        end
    end

    assign head_entry_o = mem_q[head_idx_i];

endmodule

// File: rtl/rob_commit_queue.sv
// In-order completion queue; sole writer of the architectural register file.
module rob_commit_queue
    import rob_commit_queue_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    rob_commit_queue_if.slave  bus
);

    localparam logic [rob_idx_width:0] DepthCnt = (rob_idx_width + 1)'(ROB_DEPTH);

    logic [rob_idx_width-1:0] head_q, head_d, tail_q, tail_d;
    logic [rob_idx_width:0]   count_q, count_d;
    rob_entry_t               head_entry;
    logic                     clear, alloc_fire, commit;

    // Reset and flush share one path so a mid-run reset behaves exactly like a flush.
    assign clear      = reset | bus.flush;
    assign alloc_fire = bus.alloc_valid & bus.alloc_ready & ~clear;
    assign commit     = head_entry.valid & head_entry.done & ~clear;

    rob_commit_queue_entry_array u_entries (
        .clk_i            (clk),
        .clear_i          (clear),
        .alloc_we_i       (alloc_fire),
        .alloc_idx_i      (tail_q),
        .alloc_has_dest_i (bus.alloc_has_dest),
        .alloc_dest_i     (bus.alloc_dest),
        .cdb_we_i         (bus.cdb_valid),
        .cdb_idx_i        (bus.cdb_idx),
        .cdb_data_i       (bus.cdb_data),
        .retire_we_i      (commit),
        .head_idx_i       (head_q),
        .head_entry_o     (head_entry)
    );

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (commit)     head_d = head_q + 1'b1;
        if (alloc_fire) tail_d = tail_q + 1'b1;
        case ({alloc_fire, commit})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // alloc_ready looks at count only, so a same-cycle retire never frees a slot early.
    assign bus.alloc_ready  = count_q < DepthCnt;
    assign bus.alloc_idx    = tail_q;
    assign bus.empty        = count_q == '0;
    assign bus.count        = count_q;
    assign bus.commit_valid = commit;
    assign bus.regfile_load = commit & head_entry.has_dest;
    assign bus.regfile_dest = head_entry.dest;
    assign bus.regfile_in   = head_entry.data;

endmodule

// File: tb/tb_rob_commit_queue.sv
// Bench for rob_commit_queue: directed vector table, hand sequences, random vs queue model.
module tb_rob_commit_queue;
    import rob_commit_queue_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rob_commit_queue_if bus ();

    rob_commit_queue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: program-order list of in-flight instructions plus head index.
    typedef struct {
        logic        hd;
        logic [2:0]  dst;
        logic        done;
        logic [15:0] data;
    } ment_t;

    ment_t mq[$];
    int    mhead = 0;
    int    e_cnt, e_aidx;
    logic  e_cmt, e_ld;
    logic [2:0]  e_rdst;
    logic [15:0] e_rin;

    typedef struct {
        logic        av, hd;
        logic [2:0]  dst;
        logic        cv;
        logic [2:0]  ci;
        logic [15:0] cd;
        int          cnt, aidx;
        logic        cmt, ld;
        logic [2:0]  rdst;
        logic [15:0] rin;
    } vec_t;

    function automatic vec_t mk(logic av, logic hd, logic [2:0] dst, logic cv, logic [2:0] ci,
                                logic [15:0] cd, int cnt, int aidx, logic cmt, logic ld,
                                logic [2:0] rdst, logic [15:0] rin);
        vec_t v;
        v.av = av; v.hd = hd; v.dst = dst; v.cv = cv; v.ci = ci; v.cd = cd;
        v.cnt = cnt; v.aidx = aidx; v.cmt = cmt; v.ld = ld; v.rdst = rdst; v.rin = rin;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, then at the falling edge record the model's expectation for
    // this cycle and advance the model across the coming rising edge.
    task automatic apply(input logic rst, input logic av, input logic hd, input logic [2:0] dst,
                         input logic cv, input logic [2:0] ci, input logic [15:0] cd,
                         input logic fl);
        int    sz, off;
        ment_t t;
        @(posedge clk);
        #1;
        reset              = rst;
        bus.alloc_valid    = av;
        bus.alloc_has_dest = hd;
        bus.alloc_dest     = dst;
        bus.cdb_valid      = cv;
        bus.cdb_idx        = ci;
        bus.cdb_data       = cd;
        bus.flush          = fl;
        @(negedge clk);
        sz     = mq.size();
        e_cnt  = sz;
        e_aidx = (mhead + sz) % 8;
        e_cmt  = (sz > 0) && mq[0].done && !fl && !rst;
        e_ld   = e_cmt && mq[0].hd;
        e_rdst = (sz > 0) ? mq[0].dst : 3'd0;
        e_rin  = (sz > 0) ? mq[0].data : 16'd0;
        if (rst || fl) begin
            mq.delete();
            mhead = 0;
        end else begin
            off = (int'(ci) - mhead + 8) % 8;
            if (cv && off < sz) begin
                t = mq[off];
                t.done = 1'b1;
                t.data = cd;
                mq[off] = t;
            end
            if (e_cmt) begin
                void'(mq.pop_front());
                mhead = (mhead + 1) % 8;
            end
            if (av && sz < 8) begin
                t.hd = hd; t.dst = dst; t.done = 1'b0; t.data = 16'h0;
                mq.push_back(t);
            end
        end
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0);
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " count"}, bus.count, e_cnt);
        chk({tag, " empty"}, bus.empty, e_cnt == 0);
        chk({tag, " alloc_ready"}, bus.alloc_ready, e_cnt < 8);
        chk({tag, " alloc_idx"}, bus.alloc_idx, e_aidx);
        chk({tag, " commit_valid"}, bus.commit_valid, e_cmt);
        chk({tag, " regfile_load"}, bus.regfile_load, e_ld);
        if (e_cmt) begin
            chk({tag, " regfile_dest"}, bus.regfile_dest, e_rdst);
            chk({tag, " regfile_in"}, bus.regfile_in, e_rin);
        end
    endtask

    vec_t vecs[$];

    initial begin
        bus.alloc_valid = 1'b0; bus.alloc_has_dest = 1'b0; bus.alloc_dest = '0;
        bus.cdb_valid = 1'b0; bus.cdb_idx = '0; bus.cdb_data = '0; bus.flush = 1'b0;

        // Directed table: reset state, out-of-order CDB, no-dest commit, ignored CDB,
        // alloc and commit in the same cycle.
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 3, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 5, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 1, 1, 16'hBEEF, 2, 2, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 1, 0, 16'h1234, 2, 2, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 2, 2, 1, 1, 3, 16'h1234));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 2, 1, 1, 5, 16'hBEEF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 2, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 7, 0, 0, 16'h0000, 0, 2, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 1, 2, 16'h0055, 1, 3, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 3, 1, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 1, 5, 16'h0099, 0, 3, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 0, 3, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 1, 3, 16'h7777, 1, 4, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 2, 0, 0, 16'h0000, 1, 4, 1, 1, 1, 16'h7777));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 5, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 1, 4, 16'h0ABC, 1, 5, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 5, 1, 1, 2, 16'h0ABC));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 5, 0, 0, 0, 16'h0000));

        do_reset();
        foreach (vecs[i]) begin
            apply(1'b0, vecs[i].av, vecs[i].hd, vecs[i].dst, vecs[i].cv, vecs[i].ci,
                  vecs[i].cd, 1'b0);
            chk($sformatf("vec%0d count", i), bus.count, vecs[i].cnt);
            chk($sformatf("vec%0d empty", i), bus.empty, vecs[i].cnt == 0);
            chk($sformatf("vec%0d alloc_ready", i), bus.alloc_ready, vecs[i].cnt < 8);
            chk($sformatf("vec%0d alloc_idx", i), bus.alloc_idx, vecs[i].aidx);
            chk($sformatf("vec%0d commit_valid", i), bus.commit_valid, vecs[i].cmt);
            chk($sformatf("vec%0d regfile_load", i), bus.regfile_load, vecs[i].ld);
            if (vecs[i].ld) begin
                chk($sformatf("vec%0d regfile_dest", i), bus.regfile_dest, vecs[i].rdst);
                chk($sformatf("vec%0d regfile_in", i), bus.regfile_in, vecs[i].rin);
            end
        end

        // Fill to full, ignored 9th alloc, commit does not free a slot in its own cycle.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b1, 1'b1, 3'(i), 1'b0, 3'd0, 16'h0, 1'b0);
            chk("full alloc_idx", bus.alloc_idx, i);
            chk("full count", bus.count, i);
        end
        apply(1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 16'h0, 1'b0);
        chk("full alloc_ready", bus.alloc_ready, 0);
        chk("full count8", bus.count, 8);
        apply(1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 3'd0, 16'hA0A0, 1'b0);
        chk("full 9th ignored", bus.count, 8);
        chk("full no early commit", bus.commit_valid, 0);
        apply(1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 16'h0, 1'b0);
        chk("full commit_valid", bus.commit_valid, 1);
        chk("full regfile_load", bus.regfile_load, 1);
        chk("full regfile_dest", bus.regfile_dest, 0);
        chk("full regfile_in", bus.regfile_in, 16'hA0A0);
        chk("full still not ready", bus.alloc_ready, 0);
        chk("full count on commit", bus.count, 8);
        idle();
        chk("full ready after", bus.alloc_ready, 1);
        chk("full count7", bus.count, 7);
        chk("full alloc_idx wrap", bus.alloc_idx, 0);

        // Flush with three completed entries: suppressed commit, clean state, stale CDB lost.
        do_reset();
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 1'b1, 3'(4 + i), 1'b0, 3'd0, 16'h0, 1'b0);
        for (int i = 2; i >= 0; i--) apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'(i), 16'h1000, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1);
        chk("flush commit_valid", bus.commit_valid, 0);
        chk("flush regfile_load", bus.regfile_load, 0);
        apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 16'h1111, 1'b0);
        chk("flush empty", bus.empty, 1);
        chk("flush alloc_idx", bus.alloc_idx, 0);
        chk("flush count", bus.count, 0);
        apply(1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 16'h0, 1'b0);
        idle();
        chk("flush new entry not done", bus.commit_valid, 0);
        chk("flush new count", bus.count, 1);

        // Random traffic against the queue model, including occasional flush and reset.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic       av, hd, cv, fl, rs;
            logic [2:0] ci;
            av = ($urandom % 100) < 55;
            hd = $urandom % 2;
            cv = ($urandom % 100) < 50;
            if (mq.size() > 0 && ($urandom % 4) != 0)
                ci = 3'((mhead + int'($urandom % mq.size())) % 8);
            else
                ci = 3'($urandom % 8);
            fl = ($urandom % 100) < 2;
            rs = ($urandom % 200) < 1;
            apply(rs, av, hd, 3'($urandom % 8), cv, ci, 16'($urandom), fl);
            check_model("rand");
            chk("rand count bound", bus.count <= 8, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
